// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle-path launcher/receiver pair.
// Both sides use the same state encoding and the same MCP_CYCLES bounds.
package mcp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mcp_state_t;

    localparam int unsigned MCP_MIN_CYCLES = 2;
    localparam int unsigned MCP_MAX_CYCLES = 16;

    // Width of a down-counter loaded with mcp_cycles-1; it never wraps.
    function automatic int unsigned mcp_cnt_width(input int unsigned mcp_cycles);
        return $clog2(mcp_cycles) + 1;
    endfunction

endpackage

// File: rtl/mcp_capture_rx_if.sv
// Launcher <-> receiver bundle for the multicycle capture path.
// Parity signals exist only when MCP_CAPTURE_RX_PARITY_EN is defined.
interface mcp_capture_rx_if #(
    parameter int unsigned DATA_W = 8
);

    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ack_out;
    logic              busy;
    logic              err_overrun;
`ifdef MCP_CAPTURE_RX_PARITY_EN
    logic              data_par_in;
    logic              err_parity;
`endif

    modport master (
        output req_in,
        output data_in,
`ifdef MCP_CAPTURE_RX_PARITY_EN
        output data_par_in,
        input  err_parity,
`endif
        input  data_out,
        input  valid_out,
        input  ack_out,
        input  busy,
        input  err_overrun
    );

    modport slave (
        input  req_in,
        input  data_in,
`ifdef MCP_CAPTURE_RX_PARITY_EN
        input  data_par_in,
        output err_parity,
`endif
        output data_out,
        output valid_out,
        output ack_out,
        output busy,
        output err_overrun
    );

endinterface

// File: rtl/mcp_toggle_det.sv
// Request toggle detector: registers req and flags each level change for one cycle.
// A req already high at reset release reads as a toggle on the first edge.
module mcp_toggle_det (
    input  logic clk1,
    input  logic rst_n,
    input  logic i_req,
    output logic o_toggle_c
);

    logic r_req_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q <= 1'b0;
        end else begin
            r_req_q <= i_req;
        end
    end

    assign o_toggle_c = i_req ^ r_req_q;

endmodule

// File: rtl/mcp_capture_rx.sv
// Capture endpoint of a same-clock multicycle path: waits out the launch hold window,
// samples data_in, pulses valid and toggles ack. Optional parity: MCP_CAPTURE_RX_PARITY_EN.
module mcp_capture_rx
    import mcp_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MCP_CYCLES = 2
) (
    input  logic             clk1,
    input  logic             rst_n,
    mcp_capture_rx_if.slave  bus
);

    localparam int unsigned CNT_W = mcp_cnt_width(MCP_CYCLES);

    if (MCP_CYCLES < MCP_MIN_CYCLES || MCP_CYCLES > MCP_MAX_CYCLES) begin : g_bad_mcp
        $error("mcp_capture_rx: MCP_CYCLES out of range");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("mcp_capture_rx: DATA_W out of range");
    end

    logic              w_toggle;
    mcp_state_t        r_state;
    mcp_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_capture;
    logic              w_overrun_set;

    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_ack;
    logic              r_busy;
    logic              r_err_overrun;

    mcp_toggle_det u_toggle_det (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .i_req      (bus.req_in),
        .o_toggle_c (w_toggle)
    );

    // State and window counter
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Any toggle seen in WAIT, including the capture edge, is an overrun and is dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_toggle) begin
                    w_cnt_nxt   = CNT_W'(MCP_CYCLES - 1);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_overrun_set = w_toggle;
                w_cnt_nxt     = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs; data_in -> r_data_out is the multicycle path
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out    <= '0;
            r_valid       <= 1'b0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_busy  <= (w_state_nxt == WAIT);
            if (w_capture) begin
                r_data_out <= bus.data_in;
                r_ack      <= ~r_ack;
            end
            if (w_overrun_set) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.valid_out   = r_valid;
    assign bus.ack_out     = r_ack;
    assign bus.busy        = r_busy;
    assign bus.err_overrun = r_err_overrun;

`ifdef MCP_CAPTURE_RX_PARITY_EN
    logic w_par_bad;
    logic r_err_parity;

    // Even parity: XOR of data and parity bit must be zero at the capture edge.
    assign w_par_bad = (^bus.data_in) ^ bus.data_par_in;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_err_parity <= 1'b0;
        end else if (w_capture && w_par_bad) begin
            r_err_parity <= 1'b1;
        end
    end

    assign bus.err_parity = r_err_parity;
`endif

endmodule

// File: tb/tb_mcp_capture_rx.sv
// Directed bench for mcp_capture_rx with three instances (MCP_CYCLES = 2, 3, 4).
// Parity scenario is compiled in when MCP_CAPTURE_RX_PARITY_EN is defined.
module tb_mcp_capture_rx;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_ack2 = 1'b0;

    always #5 clk1 = ~clk1;

    mcp_capture_rx_if #(.DATA_W(8)) bus2 ();
    mcp_capture_rx_if #(.DATA_W(8)) bus3 ();
    mcp_capture_rx_if #(.DATA_W(8)) bus4 ();

    mcp_capture_rx #(.DATA_W(8), .MCP_CYCLES(2)) u_dut2 (.clk1(clk1), .rst_n(rst_n), .bus(bus2));
    mcp_capture_rx #(.DATA_W(8), .MCP_CYCLES(3)) u_dut3 (.clk1(clk1), .rst_n(rst_n), .bus(bus3));
    mcp_capture_rx #(.DATA_W(8), .MCP_CYCLES(4)) u_dut4 (.clk1(clk1), .rst_n(rst_n), .bus(bus4));

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        bus2.req_in = 1'b0; bus2.data_in = 8'h00;
        bus3.req_in = 1'b0; bus3.data_in = 8'h00;
        bus4.req_in = 1'b0; bus4.data_in = 8'h00;
`ifdef MCP_CAPTURE_RX_PARITY_EN
        bus2.data_par_in = 1'b0; bus3.data_par_in = 1'b0; bus4.data_par_in = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus2.data_out, bus2.valid_out, bus2.ack_out, bus2.busy, bus2.err_overrun} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut2: got %h expected 000",
                     {bus2.data_out, bus2.valid_out, bus2.ack_out, bus2.busy, bus2.err_overrun});
        end
        n_vec++;
        if ({bus3.data_out, bus3.valid_out, bus3.ack_out, bus3.busy, bus3.err_overrun} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut3: got %h expected 000",
                     {bus3.data_out, bus3.valid_out, bus3.ack_out, bus3.busy, bus3.err_overrun});
        end
        n_vec++;
        if ({bus4.data_out, bus4.valid_out, bus4.ack_out, bus4.busy, bus4.err_overrun} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut4: got %h expected 000",
                     {bus4.data_out, bus4.valid_out, bus4.ack_out, bus4.busy, bus4.err_overrun});
        end
`ifdef MCP_CAPTURE_RX_PARITY_EN
        n_vec++;
        if (bus2.err_parity !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err_parity: got %b expected 0", bus2.err_parity);
        end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int vcnt = 0;
        bus2.data_in = 8'hA5;
        bus2.req_in  = 1'b1;
`ifdef MCP_CAPTURE_RX_PARITY_EN
        bus2.data_par_in = 1'b0;
`endif
        exp_ack2 = ~exp_ack2;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                n_vec++;
                if (bus2.busy !== 1'b1 || bus2.data_out !== 8'h00) begin
                    n_err++;
                    $display("FAIL basic_toggle_edge: busy=%b data=%h expected busy=1 data=00",
                             bus2.busy, bus2.data_out);
                end
            end
            if (i == 1) begin
                n_vec++;
                if (bus2.data_out !== 8'hA5 || bus2.ack_out !== 1'b1 || bus2.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_capture: data=%h ack=%b busy=%b expected a5/1/0",
                             bus2.data_out, bus2.ack_out, bus2.busy);
                end
            end
            if (bus2.valid_out === 1'b1) begin
                vcnt++;
                n_vec++;
                if (bus2.data_out !== 8'hA5) begin
                    n_err++;
                    $display("FAIL basic_valid_data: got %h expected a5", bus2.data_out);
                end
            end
        end
        n_vec++;
        if (vcnt != 1) begin
            n_err++;
            $display("FAIL basic_valid_count: got %0d expected 1", vcnt);
        end
    endtask

`ifdef MCP_CAPTURE_RX_PARITY_EN
    task automatic test_parity();
        int vcnt = 0;
        bus2.data_in     = 8'h07;
        bus2.data_par_in = 1'b0;
        bus2.req_in      = ~bus2.req_in;
        exp_ack2         = ~exp_ack2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus2.valid_out === 1'b1) vcnt++;
        end
        n_vec++;
        if (bus2.data_out !== 8'h07 || vcnt != 1 || bus2.err_parity !== 1'b1) begin
            n_err++;
            $display("FAIL parity_bad_word: data=%h valids=%0d err_parity=%b expected 07/1/1",
                     bus2.data_out, vcnt, bus2.err_parity);
        end
        bus2.data_in     = 8'h03;
        bus2.data_par_in = 1'b0;
        bus2.req_in      = ~bus2.req_in;
        exp_ack2         = ~exp_ack2;
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (bus2.data_out !== 8'h03 || bus2.err_parity !== 1'b1 || bus2.ack_out !== exp_ack2) begin
            n_err++;
            $display("FAIL parity_sticky: data=%h err_parity=%b ack=%b expected 03/1/%b",
                     bus2.data_out, bus2.err_parity, bus2.ack_out, exp_ack2);
        end
    endtask
`endif

    task automatic test_capture_edge_collision();
        int vcnt = 0;
        bus2.data_in = 8'h6C;
`ifdef MCP_CAPTURE_RX_PARITY_EN
        bus2.data_par_in = 1'b0;
`endif
        bus2.req_in = ~bus2.req_in;
        exp_ack2    = ~exp_ack2;
        tick();
        bus2.req_in = ~bus2.req_in;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus2.valid_out === 1'b1) vcnt++;
            if (i == 0) begin
                n_vec++;
                if (bus2.err_overrun !== 1'b1 || bus2.data_out !== 8'h6C) begin
                    n_err++;
                    $display("FAIL collision_edge: overrun=%b data=%h expected 1/6c",
                             bus2.err_overrun, bus2.data_out);
                end
            end
        end
        n_vec++;
        if (vcnt != 1 || bus2.ack_out !== exp_ack2) begin
            n_err++;
            $display("FAIL collision_dropped: valids=%0d ack=%b expected 1/%b",
                     vcnt, bus2.ack_out, exp_ack2);
        end
    endtask

    task automatic test_window();
        int vcnt = 0;
        int bcnt = 0;
        bus4.data_in = 8'h3C;
        bus4.req_in  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus4.busy === 1'b1) bcnt++;
            if (bus4.valid_out === 1'b1) vcnt++;
            n_vec++;
            if (bus4.data_out === 8'hFF) begin
                n_err++;
                $display("FAIL window_late_data: cycle %0d got %h expected not ff", i, bus4.data_out);
            end
            if (i == 3) bus4.data_in = 8'hFF;
        end
        n_vec++;
        if (bcnt != 3) begin
            n_err++;
            $display("FAIL window_busy_cycles: got %0d expected 3", bcnt);
        end
        n_vec++;
        if (bus4.data_out !== 8'h3C || vcnt != 1 || bus4.ack_out !== 1'b1) begin
            n_err++;
            $display("FAIL window_capture: data=%h valids=%0d ack=%b expected 3c/1/1",
                     bus4.data_out, vcnt, bus4.ack_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int vcnt = 0;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        for (int j = 0; j < 14; j++) begin
            if (j % 3 == 0 && j < 9) begin
                bus3.data_in = words[j / 3];
                bus3.req_in  = ~bus3.req_in;
            end
            tick();
            if (bus3.valid_out === 1'b1) begin
                n_vec++;
                if (vcnt < 3 && bus3.data_out !== words[vcnt]) begin
                    n_err++;
                    $display("FAIL b2b_word%0d: got %h expected %h", vcnt, bus3.data_out, words[vcnt]);
                end
                vcnt++;
            end
        end
        n_vec++;
        if (vcnt != 3) begin
            n_err++;
            $display("FAIL b2b_valid_count: got %0d expected 3", vcnt);
        end
        n_vec++;
        if (bus3.ack_out !== 1'b1 || bus3.err_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ack_overrun: ack=%b overrun=%b expected 1/0",
                     bus3.ack_out, bus3.err_overrun);
        end
    endtask

    task automatic test_overrun();
        int vcnt = 0;
        bus4.data_in = 8'h5A;
        bus4.req_in  = 1'b0;
        tick();
        if (bus4.valid_out === 1'b1) vcnt++;
        bus4.req_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin
                n_vec++;
                if (bus4.err_overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL overrun_set: got %b expected 1", bus4.err_overrun);
                end
            end
            if (bus4.valid_out === 1'b1) begin
                vcnt++;
                n_vec++;
                if (bus4.data_out !== 8'h5A) begin
                    n_err++;
                    $display("FAIL overrun_data: got %h expected 5a", bus4.data_out);
                end
            end
        end
        n_vec++;
        if (vcnt != 1 || bus4.ack_out !== 1'b0 || bus4.err_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_final: valids=%0d ack=%b overrun=%b expected 1/0/1",
                     vcnt, bus4.ack_out, bus4.err_overrun);
        end
    endtask

    task automatic test_reset_mid_wait();
        int vcnt4 = 0;
        int vcnt2 = 0;
        bus4.data_in = 8'h99;
        bus4.req_in  = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus4.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_precond: busy=%b expected 1", bus4.busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus4.data_out, bus4.valid_out, bus4.ack_out, bus4.busy, bus4.err_overrun} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_wait_async: got %h expected 000",
                     {bus4.data_out, bus4.valid_out, bus4.ack_out, bus4.busy, bus4.err_overrun});
        end
        // req high across release must be seen as a fresh toggle
        bus2.req_in  = 1'b1;
        bus2.data_in = 8'hC3;
`ifdef MCP_CAPTURE_RX_PARITY_EN
        bus2.data_par_in = 1'b0;
`endif
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus4.valid_out === 1'b1) vcnt4++;
            if (bus2.valid_out === 1'b1) vcnt2++;
        end
        n_vec++;
        if (vcnt4 != 0 || bus4.ack_out !== 1'b0 || bus4.data_out !== 8'h00) begin
            n_err++;
            $display("FAIL rst_wait_lost: valids=%0d ack=%b data=%h expected 0/0/00",
                     vcnt4, bus4.ack_out, bus4.data_out);
        end
        n_vec++;
        if (vcnt2 != 1 || bus2.ack_out !== 1'b1 || bus2.data_out !== 8'hC3) begin
            n_err++;
            $display("FAIL rst_release_req_high: valids=%0d ack=%b data=%h expected 1/1/c3",
                     vcnt2, bus2.ack_out, bus2.data_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef MCP_CAPTURE_RX_PARITY_EN
        test_parity();
`endif
        test_capture_edge_collision();
        test_window();
        test_back_to_back();
        test_overrun();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcp_capture_rx.md
# mcp_capture_rx

Capture side of a same-clock multicycle-path transfer. A launcher holds `data_in` stable for `MCP_CYCLES` clock cycles and announces each word by toggling `req_in`. This block detects the toggle, waits out the multicycle window and samples the held data. It then pulses `valid_out` and returns a toggle on `ack_out`. It is the receiving counterpart to the multicycle launch registers in the timing benchmark suite, and it gives the SDC `set_multicycle_path -setup MCP_CYCLES` on `data_in -> data_out` a functionally correct endpoint.

## Interface
- `DATA_W`, default 8: data width in bits, range 1..64.
- `MCP_CYCLES`, default 2: setup multiplier, range 2..16. Any value outside this range is an elaboration error.
- `clk1`  in  1  single clock. All logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_in`  in  1  request toggle from the launcher. Each level change is one word.
- `data_in`  in  DATA_W  launched data, held stable ≥ `MCP_CYCLES` cycles from the toggle.
- `data_out`  out  DATA_W  captured word, held until the next capture.
- `valid_out`  out  1  one-cycle pulse, asserted in the cycle after each capture.
- `ack_out`  out  1  acknowledge toggle back to the launcher.
- `busy`  out  1  high while in the WAIT state.
- `err_overrun`  out  1  sticky flag. Cleared only by reset.

## Operation
- Reset values: `data_out`=0, `valid_out`=0, `ack_out`=0, `busy`=0, `err_overrun`=0, internal `req_q`=0, state=IDLE, `cnt`=0.
- `req_q` samples `req_in` every cycle. A toggle event is `req_in ^ req_q`.
- If `req_in` is 1 at reset release, it counts as a toggle at the first edge.
- State machine has two states, IDLE and WAIT.
- IDLE:
  - On a toggle event at edge E0: load `cnt` = `MCP_CYCLES`-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `cnt` decrements each edge.
  - At the edge where `cnt`==1: `data_out` ← `data_in`, `ack_out` toggles, `valid_out` is driven high for the following cycle, and the state returns to IDLE.
- Capture happens at edge E0+`MCP_CYCLES`-1, which is the last edge of the launcher's hold window.
- Toggle during WAIT: `err_overrun` sets. The in-flight capture completes unchanged and the new toggle is dropped, so no extra capture occurs.
- Toggle at the same edge as a capture: treated as arriving during WAIT. It sets `err_overrun` and is dropped.
- A toggle at E0+`MCP_CYCLES` (first IDLE cycle) is accepted normally. Back-to-back throughput is one word per `MCP_CYCLES` cycles.
- Reset asserted mid-WAIT: all outputs return to reset values immediately (asynchronously). The pending capture is lost and no `ack_out` toggle is issued.

## Timing
- Latency, toggle-sampled edge to `data_out` update: `MCP_CYCLES`-1 edges. `valid_out` follows one cycle later.
- `data_in` → `data_out` is the only multicycle path, with setup `MCP_CYCLES`, hold `MCP_CYCLES`-1.
- `req_in` → `req_q` and the state/ack logic are single-cycle paths.
- `cnt` width is $clog2(`MCP_CYCLES`)+1 bits. It never wraps, because reload happens only in IDLE.

## Configuration
- Macro `MCP_CAPTURE_RX_PARITY_EN`.
- Defined:
  - Adds input `data_par_in` (1 bit, even parity over `data_in`, same multicycle hold).
  - Adds output `err_parity` (1 bit, sticky, reset 0).
  - Parity is checked at the capture edge. On mismatch, `err_parity` sets.
  - `data_out`, `valid_out` and `ack_out` behave as in the base mode, so the word is still delivered.
- Undefined: neither port exists and no parity logic is synthesized.

## Structure
- Shared package `mcp_pkg`:
  - state enum `mcp_state_t` {IDLE, WAIT}.
  - constants `MCP_MIN_CYCLES`=2 and `MCP_MAX_CYCLES`=16, used by both launcher and receiver.
- One sub-module, `mcp_toggle_det`: holds `req_q` and outputs the one-cycle toggle event.
- Counter, state machine and capture register live in the top.

## Test plan
- Basic capture, `MCP_CYCLES`=2, `DATA_W`=8: toggle `req_in` 0→1 with `data_in`=0xA5 → `data_out`=0xA5 one edge after the toggle is sampled, `valid_out` pulses once, `ack_out`=1.
- Window timing, `MCP_CYCLES`=4: toggle with 0x3C held for 4 cycles, and `data_in` changed to 0xFF at cycle 4 → `data_out`=0x3C, never 0xFF. `busy` is high for exactly 3 cycles.
- Back-to-back, `MCP_CYCLES`=3: send 0x11, 0x22, 0x33 each exactly 3 cycles apart → three `valid_out` pulses, `ack_out` ends at 1 (three toggles from 0), `err_overrun`=0.
- Overrun, `MCP_CYCLES`=4: second toggle 1 cycle after the first → first word captured, only one `valid_out` pulse, `err_overrun`=1 and stays 1.
- Reset mid-WAIT, `MCP_CYCLES`=4: assert `rst_n`=0 two cycles after the toggle → outputs are 0 immediately, and after release there is no `valid_out` pulse and `ack_out` remains 0.
- `MCP_CAPTURE_RX_PARITY_EN` defined: send 0x07 with `data_par_in`=0 (wrong parity) → `data_out`=0x07, `valid_out` pulses, `err_parity`=1. A following correct-parity word leaves `err_parity` at 1.
